// File: rtl/batalha_pkg.sv
// Shared board constants, ship type codes, vector field layout and placement states.
package batalha_pkg;

   localparam int unsigned MAP_SIZE    = 8;
   localparam int unsigned X_LSB       = 3;
   localparam int unsigned Y_LSB       = 7;
   localparam int unsigned CELL_STRIDE = 8;
   localparam int unsigned LOCK_BIT    = 63;

   typedef enum logic [2:0] {
      SUBMARINO    = 3'd1,
      CRUZADOR     = 3'd2,
      HIDROAVIAO   = 3'd3,
      ENCOURACADO  = 3'd4,
      PORTA_AVIOES = 3'd5
   } tipo_t;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      CHECK,
      PLACED
   } estado_t;

   // Board coordinates are 1-based; occupancy bit is (y-1)*8 + (x-1).
   function automatic logic [5:0] occ_index(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] xm;
      logic [3:0] ym;
      xm = x - 4'd1;
      ym = y - 4'd1;
      return 6'({ym, 3'b000} + 7'(xm));
   endfunction

endpackage

// File: rtl/verificador_colisao.sv
// Occupancy scanner: after start, tests one ship cell per cycle (cell 0 first) and
// pulses done with the accumulated hit flag once the last cell has been tested.
module verificador_colisao
   import batalha_pkg::*;
#(
   parameter int unsigned NUM_CELLS = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  anchor,
   input  logic        orientation,
   input  logic [63:0] ocupado,
   output logic        done,
   output logic        hit
);

   localparam logic [2:0] LAST = 3'(NUM_CELLS - 1);

   logic       busy;
   logic       acc;
   logic [2:0] idx;
   logic [3:0] cellX;
   logic [3:0] cellY;
   logic       cellHit;

   always_comb begin
      cellX   = anchor[3:0] + (orientation ? 4'd0 : {1'b0, idx});
      cellY   = anchor[7:4] + (orientation ? {1'b0, idx} : 4'd0);
      cellHit = ocupado[occ_index(cellX, cellY)];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy <= 1'b0;
         acc  <= 1'b0;
         idx  <= '0;
         done <= 1'b0;
         hit  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy <= 1'b1;
            acc  <= 1'b0;
            idx  <= '0;
         end else if (busy) begin
            if (idx == LAST) begin
               busy <= 1'b0;
               done <= 1'b1;
               hit  <= acc | cellHit;
            end else begin
               idx <= idx + 3'd1;
               acc <= acc | cellHit;
            end
         end
      end
   end

endmodule

// File: rtl/posicionador_embarcacao.sv
// Ship placement controller: cursor moves/rotation, occupancy-checked confirm, packed vector out.
// Build option POSICIONADOR_WRAP_EN: moves past a limit wrap around instead of clamping.
module posicionador_embarcacao
   import batalha_pkg::*;
#(
   parameter int unsigned NUM_CELLS = 4,
   parameter logic [2:0]  TIPO      = ENCOURACADO
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        iniciar,
   input  logic        btn_cima,
   input  logic        btn_baixo,
   input  logic        btn_esq,
   input  logic        btn_dir,
   input  logic        btn_girar,
   input  logic        btn_confirmar,
   input  logic [63:0] ocupado,
   output logic [63:0] posicoesEmbarcacao,
   output logic        posicionado,
   output logic        colisao
);

`ifdef POSICIONADOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam logic [3:0] MAP_MAX = 4'(MAP_SIZE);
   localparam logic [3:0] RUN_MAX = 4'(MAP_SIZE + 1 - NUM_CELLS);

   function automatic logic [3:0] stepAxis(input logic [3:0] v, input logic [3:0] lim,
                                           input logic up);
      if (up) return (v < lim) ? v + 4'd1 : (WRAP ? 4'd1 : v);
      else    return (v > 4'd1) ? v - 4'd1 : (WRAP ? lim : v);
   endfunction

   logic rstMeta, rstSync;

   // Internal reset asserts asynchronously but releases two clocks after reset_n rises.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) {rstMeta, rstSync} <= 2'b00;
      else          {rstMeta, rstSync} <= {1'b1, rstMeta};
   end

   estado_t     state, nextState;
   logic [3:0]  ax, ay, nextAx, nextAy, maxX, maxY;
   logic        vert, nextVert;
   logic        scanStart, scanDone, scanHit;
   logic [63:0] nextVetor;

   always_comb begin
      nextState = state;
      nextAx    = ax;
      nextAy    = ay;
      nextVert  = vert;
      scanStart = 1'b0;
      maxX      = vert ? MAP_MAX : RUN_MAX;
      maxY      = vert ? RUN_MAX : MAP_MAX;
      case (state)
         IDLE, PLACED: begin
            if (iniciar) begin
               nextState = MOVE;
               nextAx    = 4'd1;
               nextAy    = 4'd1;
               nextVert  = 1'b0;
            end
         end
         MOVE: begin
            if (btn_confirmar) begin
               nextState = CHECK;
               scanStart = 1'b1;
            end else if (btn_girar) begin
               if (vert ? (ax <= RUN_MAX) : (ay <= RUN_MAX)) nextVert = ~vert;
            end else if (btn_cima)  nextAy = stepAxis(ay, maxY, 1'b1);
            else if (btn_baixo)     nextAy = stepAxis(ay, maxY, 1'b0);
            else if (btn_esq)       nextAx = stepAxis(ax, maxX, 1'b0);
            else if (btn_dir)       nextAx = stepAxis(ax, maxX, 1'b1);
         end
         CHECK: begin
            if (scanDone) nextState = scanHit ? MOVE : PLACED;
         end
         default: nextState = IDLE;
      endcase

      nextVetor = '0;
      if (nextState != IDLE) begin
         nextVetor[2:0] = TIPO;
         for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            nextVetor[X_LSB + CELL_STRIDE*k +: 4] = nextVert ? nextAx : nextAx + 4'(k);
            nextVetor[Y_LSB + CELL_STRIDE*k +: 4] = nextVert ? nextAy + 4'(k) : nextAy;
         end
         nextVetor[LOCK_BIT] = (nextState == PLACED);
      end
   end

   always_ff @(posedge clk or negedge rstSync) begin
      if (!rstSync) begin
         state              <= IDLE;
         ax                 <= 4'd1;
         ay                 <= 4'd1;
         vert               <= 1'b0;
         posicoesEmbarcacao <= '0;
         posicionado        <= 1'b0;
         colisao            <= 1'b0;
      end else begin
         state              <= nextState;
         ax                 <= nextAx;
         ay                 <= nextAy;
         vert               <= nextVert;
         posicoesEmbarcacao <= nextVetor;
         posicionado        <= (nextState == PLACED);
         colisao            <= (state == CHECK) && scanDone && scanHit;
      end
   end

   verificador_colisao #(.NUM_CELLS(NUM_CELLS)) u_verificador (
      .clk         (clk),
      .reset_n     (rstSync),
      .start       (scanStart),
      .anchor      ({ay, ax}),
      .orientation (vert),
      .ocupado     (ocupado),
      .done        (scanDone),
      .hit         (scanHit)
   );

endmodule

// File: tb/tb_posicionador_embarcacao.sv
// Directed plus randomized bench for posicionador_embarcacao against a cell-level reference model.
module tb_posicionador_embarcacao;

   localparam int         N    = 4;
   localparam logic [2:0] TIPO = 3'd4;

   localparam logic [6:0] P_INI = 7'b1000000;
   localparam logic [6:0] P_CF  = 7'b0100000;
   localparam logic [6:0] P_GI  = 7'b0010000;
   localparam logic [6:0] P_UP  = 7'b0001000;
   localparam logic [6:0] P_DN  = 7'b0000100;
   localparam logic [6:0] P_LF  = 7'b0000010;
   localparam logic [6:0] P_RT  = 7'b0000001;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        iniciar = 1'b0, btn_cima = 1'b0, btn_baixo = 1'b0, btn_esq = 1'b0;
   logic        btn_dir = 1'b0, btn_girar = 1'b0, btn_confirmar = 1'b0;
   logic [63:0] ocupado = '0;
   logic [63:0] vetor;
   logic        posicionado, colisao;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   posicionador_embarcacao #(.NUM_CELLS(N), .TIPO(TIPO)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .iniciar            (iniciar),
      .btn_cima           (btn_cima),
      .btn_baixo          (btn_baixo),
      .btn_esq            (btn_esq),
      .btn_dir            (btn_dir),
      .btn_girar          (btn_girar),
      .btn_confirmar      (btn_confirmar),
      .ocupado            (ocupado),
      .posicoesEmbarcacao (vetor),
      .posicionado        (posicionado),
      .colisao            (colisao)
   );

   // Reference model: phase 0 idle, 1 moving, 2 checking, 3 placed.
   int mPhase = 0;
   int mX = 1, mY = 1, mCnt = 0;
   bit mV = 1'b0, mHit = 1'b0, expCol = 1'b0;

   function automatic bit fits(int x, int y, bit v);
      for (int k = 0; k < N; k++) begin
         int cx, cy;
         cx = v ? x : x + k;
         cy = v ? y + k : y;
         if (cx < 1 || cx > 8 || cy < 1 || cy > 8) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit cellsHit();
      for (int k = 0; k < N; k++) begin
         int cx, cy;
         cx = mV ? mX : mX + k;
         cy = mV ? mY + k : mY;
         if (ocupado[(cy - 1) * 8 + cx - 1]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int stepAxis(int cur, int d, bit isX);
      int nx;
      nx = cur + d;
      if (isX ? fits(nx, mY, mV) : fits(mX, nx, mV)) return nx;
`ifdef POSICIONADOR_WRAP_EN
      if (d > 0) return 1;
      for (int v = 8; v >= 1; v--)
         if (isX ? fits(v, mY, mV) : fits(mX, v, mV)) return v;
`endif
      return cur;
   endfunction

   function automatic logic [63:0] expVec();
      logic [63:0] v;
      v = '0;
      if (mPhase == 0) return v;
      v[2:0] = TIPO;
      for (int k = 0; k < N; k++) begin
         int cx, cy;
         cx = mV ? mX : mX + k;
         cy = mV ? mY + k : mY;
         v[3 + 8*k +: 4] = 4'(cx);
         v[7 + 8*k +: 4] = 4'(cy);
      end
      v[63] = (mPhase == 3);
      return v;
   endfunction

   task automatic modelEdge(input logic [6:0] p);
      expCol = 1'b0;
      case (mPhase)
         0, 3: if (p[6]) begin mPhase = 1; mX = 1; mY = 1; mV = 1'b0; end
         1: begin
            if (p[5]) begin mPhase = 2; mCnt = 0; mHit = cellsHit(); end
            else if (p[4]) begin if (fits(mX, mY, !mV)) mV = !mV; end
            else if (p[3]) mY = stepAxis(mY, 1, 1'b0);
            else if (p[2]) mY = stepAxis(mY, -1, 1'b0);
            else if (p[1]) mX = stepAxis(mX, -1, 1'b1);
            else if (p[0]) mX = stepAxis(mX, 1, 1'b1);
         end
         2: begin
            mCnt++;
            if (mCnt == N + 1) begin
               if (mHit) begin expCol = 1'b1; mPhase = 1; end
               else mPhase = 3;
            end
         end
         default: mPhase = 0;
      endcase
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkAll();
      check("vetor", vetor, expVec());
      check("posicionado", {63'd0, posicionado}, {63'd0, mPhase == 3});
      check("colisao", {63'd0, colisao}, {63'd0, expCol});
   endtask

   task automatic step(input logic [6:0] p);
      {iniciar, btn_confirmar, btn_girar, btn_cima, btn_baixo, btn_esq, btn_dir} = p;
      @(posedge clk);
      modelEdge(p);
      #1;
      {iniciar, btn_confirmar, btn_girar, btn_cima, btn_baixo, btn_esq, btn_dir} = '0;
      checkAll();
   endtask

   task automatic moveTo(input int x, input int y, input bit v);
      for (int i = 0; i < 20 && mX > 1; i++) step(P_LF);
      for (int i = 0; i < 20 && mY > 1; i++) step(P_DN);
      if (mV != v) step(P_GI);
      for (int i = 0; i < 20 && mY < y; i++) step(P_UP);
      for (int i = 0; i < 20 && mX < x; i++) step(P_RT);
   endtask

   initial begin
      logic [6:0] p;

      #1;
      check("rst_vetor", vetor, 64'd0);
      check("rst_posicionado", {63'd0, posicionado}, 64'd0);
      check("rst_colisao", {63'd0, colisao}, 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) step(7'd0);
      step(P_RT);

      step(P_INI);
      check("init_const", vetor, 64'h0000_0000_A098_908C);

      repeat (6) step(P_RT);
      step(P_GI);
      repeat (5) step(P_UP);
      step(P_GI);

      ocupado = 64'd1 << 18;
      moveTo(1, 3, 1'b0);
      step(P_CF);
      repeat (N + 1) step(7'd0);
      step(P_RT);

      moveTo(1, 4, 1'b0);
      step(P_CF | P_RT);
      repeat (N + 1) step(7'd0);
      step(P_RT);
      step(P_UP);
      step(P_GI);
      step(P_CF);

      step(P_INI);
      step(P_CF);
      step(7'd0);
      step(P_INI);
      #2 reset_n = 1'b0;
      #1;
      check("midcheck_vetor", vetor, 64'd0);
      check("midcheck_posicionado", {63'd0, posicionado}, 64'd0);
      check("midcheck_colisao", {63'd0, colisao}, 64'd0);
      mPhase = 0;
      expCol = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (8) step(7'd0);

      step(P_INI);
      for (int c = 0; c < 400; c++) begin
         p = '0;
         if ($urandom_range(0, 39) == 0) p[6] = 1'b1;
         if ($urandom_range(0, 14) == 0) p[5] = 1'b1;
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, 3) == 0) p[b] = 1'b1;
         if (mPhase != 2 && $urandom_range(0, 9) == 0)
            ocupado = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         step(p);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
